// File: rtl/lvt_rd_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lvt_rd_streamer : burst reader on lvt_bram rd0, credit-limited FIFO,     |
// |                   valid/ready output stream.          Revision: 1.0      |
// +--------------------------------------------------------------------------+
module lvt_rd_streamer #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 5,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining;
  logic              mem_rd_last;
  logic [OCC_W-1:0]  used;
  logic              pop;

  assign pop = out_valid & out_ready;

  // remaining counts words not yet scheduled; used counts words in flight or buffered
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = next_addr;
    issue_left = remaining;
    case (state)
      IDLE: begin
        issue_addr = base_addr;
        issue_left = count;
        if (start) begin
          if (count == '0) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
            issue      = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_next = DRAIN;
        end else if (used < DEPTH_C) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_rd_last <= 1'b0;
      next_addr   <= '0;
      remaining   <= '0;
      used        <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      mem_rd_en <= issue;
      used      <= used + OCC_W'(issue) - OCC_W'(pop);
      if (issue) begin
        mem_rd_addr <= issue_addr;
        mem_rd_last <= (issue_left == ONE_C);
        next_addr   <= issue_addr + 1'b1;
        remaining   <= issue_left - 1'b1;
      end
    end
  end

  // Issue flags ride alongside the memory latency; the tail stage pushes
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_l;
  logic              push;
  logic [DATA_W:0]   push_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      pipe_v[0] <= mem_rd_en;
      pipe_l[0] <= mem_rd_en & mem_rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  assign push      = pipe_v[RD_LAT-1];
  assign push_word = {pipe_l[RD_LAT-1], mem_rd_data};

  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_kept;

  assign rd_ptr_next = rd_ptr + PTR_W'(pop);
  assign occ_kept    = occ - OCC_W'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  // Head registers reload from storage, or straight from the push when the FIFO drains empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      occ    <= occ_kept + OCC_W'(push);
      if (occ_kept == '0) begin
        out_valid <= push;
        if (push) {out_last, out_data} <= push_word;
      end else begin
        out_valid              <= 1'b1;
        {out_last, out_data}   <= fifo_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (occ_kept < DEPTH_C);
  end

endmodule
`default_nettype wire

// File: tb/tb_lvt_rd_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lvt_rd_streamer : vector table plus scoreboard bench for the reader.  |
// |                                                      Revision: 1.0      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lvt_rd_streamer;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 5;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  always #5 clk = ~clk;

  lvt_rd_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  // Memory model: one-cycle registered read port
  logic [DATA_W-1:0] ram [2**ADDR_W];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W:0]   exp_word_q [$];
  int n_reads, n_words, n_done, first_rd_cyc, first_out_cyc, done_cyc;

  always @(negedge clk) begin
    logic [DATA_W:0] w;
    if (rst !== 1'b1) begin
      if (mem_rd_en) begin
        n_reads++;
        if (n_reads == 1) first_rd_cyc = cyc;
        if (exp_addr_q.size() != 0) check("rd_addr", int'(mem_rd_addr), int'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        n_words++;
        if (n_words == 1) first_out_cyc = cyc;
        if (exp_word_q.size() != 0) begin
          w = exp_word_q.pop_front();
          check("out_data", int'(out_data), int'(w[DATA_W-1:0]));
          check("out_last", int'(out_last), int'(w[DATA_W]));
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_reads = 0; n_words = 0; n_done = 0;
    first_rd_cyc = -1; first_out_cyc = -1; done_cyc = -1;
    exp_addr_q.delete();
    exp_word_q.delete();
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   cnt;
    bit                bp;
    bit                poke;
    int                exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vector(input vec_t v);
    int t0;
    int lim;
    int exp_bp;
    logic [ADDR_W-1:0] a;
    clear_mon();
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = v.base + i[ADDR_W-1:0];
      exp_addr_q.push_back(a);
      exp_word_q.push_back({(i == int'(v.cnt) - 1), ram[a]});
    end
    out_ready = !v.bp;
    start = 1'b1; base_addr = v.base; count = v.cnt; t0 = cyc;
    tick();
    start = 1'b0; base_addr = '0; count = '0;
    check("busy_rise", int'(busy), 1);
    if (v.poke) begin
      tick();
      start = 1'b1; base_addr = v.base + 7'd60; count = 8'd3;
      tick();
      start = 1'b0;
    end
    if (v.bp) begin
      repeat (20) tick();
      exp_bp = (int'(v.cnt) < FIFO_DEPTH) ? int'(v.cnt) : FIFO_DEPTH;
      check("bp_reads", n_reads, exp_bp);
      check("bp_rd_en_low", int'(mem_rd_en), 0);
      check("bp_valid", int'(out_valid), 1);
      check("bp_head", int'(out_data), int'(ram[v.base]));
      out_ready = 1'b1;
    end
    lim = 0;
    while (n_done == 0 && lim < 300) begin
      tick();
      lim++;
    end
    repeat (3) tick();
    check("done_pulses", n_done, 1);
    check("reads", n_reads, int'(v.cnt));
    check("words", n_words, int'(v.cnt));
    check("busy_fall", int'(busy), 0);
    if (v.exp_done >= 0) check("done_cycle", done_cyc - t0, v.exp_done);
    if (v.cnt != 0) check("first_rd_cycle", first_rd_cyc - t0, 1);
    if (v.cnt != 0 && !v.bp) check("first_out_cycle", first_out_cyc - t0, RD_LAT + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = DATA_W'((i * 7 + 3) % 32);
    ram[10] = 5'd5; ram[11] = 5'd6; ram[12] = 5'd7; ram[13] = 5'd8;

    vecs[0] = '{7'd10,  8'd4,  1'b0, 1'b0, 7};
    vecs[1] = '{7'd126, 8'd4,  1'b0, 1'b0, 7};
    vecs[2] = '{7'd0,   8'd0,  1'b0, 1'b0, 1};
    vecs[3] = '{7'd40,  8'd1,  1'b0, 1'b0, 4};
    vecs[4] = '{7'd50,  8'd8,  1'b1, 1'b0, -1};
    vecs[5] = '{7'd20,  8'd6,  1'b0, 1'b1, 9};
    vecs[6] = '{7'd100, 8'd12, 1'b0, 1'b0, 15};
    vecs[7] = '{7'd120, 8'd16, 1'b0, 1'b0, 19};

    clear_mon();
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_rd_addr", int'(mem_rd_addr), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_last", int'(out_last), 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vector(vecs[k]);

    // Reset during a 4-word burst, then a clean rerun
    clear_mon();
    out_ready = 1'b0;
    start = 1'b1; base_addr = 7'd10; count = 8'd4; t0 = cyc;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rd_en", int'(mem_rd_en), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_last", int'(out_last), 0);
    rst = 1'b0;
    clear_mon();
    out_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_reads", n_reads, 0);
    check("post_rst_words", n_words, 0);
    check("post_rst_done", n_done, 0);
    run_vector(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lvt_rd_streamer.md
# lvt_rd_streamer

Read-side streaming engine for the `lvt_bram` 2-write/1-read memory.
- Owns the memory's `rd0` port: issues a burst of sequential reads from a start address, absorbs the fixed read latency, and buffers returned words in a small FIFO.
- Presents the words to a downstream consumer over a valid/ready stream.
- Pairs with the write-side producers on `wr0`/`wr1` and is the reader at the other end of that memory.

## Interface
- `ADDR_W`, 7, memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 5, memory/stream data width.
- `RD_LAT`, 1, cycles from `mem_rd_en` high to `mem_rd_data` valid (1..4).
- `FIFO_DEPTH`, 4, output buffer entries (power of two, ≥ RD_LAT+1).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin burst; sampled only in IDLE.
- `base_addr` in ADDR_W: first read address, captured with `start`.
- `count` in ADDR_W+1: words to read (0..2^ADDR_W), captured with `start`.
- `busy` out 1: high from cycle after accepted `start` until `done` cycle inclusive.
- `done` out 1: one-cycle pulse at burst completion.
- `mem_rd_en` out 1: read strobe to `lvt_bram.rd0_en`.
- `mem_rd_addr` out ADDR_W: to `lvt_bram.rd0_addr`.
- `mem_rd_data` in DATA_W: from `lvt_bram.rd0_data` (low DATA_W bits).
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_data` out DATA_W: stream word.
- `out_last` out 1: marks final word of burst; qualified by `out_valid`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 captures `base_addr`/`count`; count≠0 → ISSUE, count=0 → DONE (no reads). `start` in any other state ignored.
- ISSUE: assert `mem_rd_en` with `mem_rd_addr`=current address when credit available, i.e. registered (FIFO occupancy + in-flight reads) < FIFO_DEPTH; no same-cycle pop bypass. Each issue increments address (wrap 2^ADDR_W−1 → 0) and decrements remaining. After last issue → DRAIN.
- In-flight tracking: RD_LAT-deep shift register of issue flags plus a last-flag; when a flag emerges, `mem_rd_data` is pushed into FIFO with its last-flag. FIFO cannot overflow by construction; overflow is an assertion failure.
- DRAIN: wait until final word (out_last) handshakes → DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1; next cycle IDLE.
- Output: `out_valid`=FIFO non-empty; `out_data`/`out_last` from FIFO head, held stable while `out_valid`&&!`out_ready`. Transfer on `out_valid`&&`out_ready`.
- Simultaneous push and pop on a full or empty FIFO handled correctly (occupancy unchanged / word passes through next cycle).
- Reset mid-burst: state→IDLE, FIFO and in-flight pipeline cleared, returning data discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- All outputs registered except `out_valid`/`out_data`/`out_last` (FIFO head registers, no combinational path from `out_ready`).
- `start` accepted at edge T → `busy`=1 and first `mem_rd_en` in cycle T+1.
- Read issued in cycle C → word pushed at end of cycle C+RD_LAT → `out_valid` in C+RD_LAT+1.
- With `out_ready` held high, one word per cycle sustained; N-word burst: last word out at cycle T+N+RD_LAT+1, `done` one cycle after its handshake.
- count=0: `done` and `busy` high in cycle T+1, back to IDLE at T+2.

## Test plan
- Reset: hold `rst` 2 cycles mid-stream → all outputs 0 next cycle, no further `mem_rd_en`, FIFO empty.
- Basic: preload addr 10..13 = 5,6,7,8; start base 10 count 4, `out_ready`=1 → `mem_rd_en` cycles T+1..T+4 with addr 10..13; out 5,6,7,8 at T+3..T+6, `out_last` on 8; `done` at T+7.
- Backpressure: count 8, `out_ready`=0 → exactly FIFO_DEPTH reads issued then `mem_rd_en` low; release ready → remaining 4 issued, all 8 words in order, none lost or duplicated.
- Wrap: base 126 count 4 → addresses 126,127,0,1 read; data order matches.
- count=0 → no `mem_rd_en`, `done` pulse at T+1; `start` pulsed while busy → ignored, burst unaffected.
- Reset at cycle T+3 of a 4-word burst → no `out_valid` after reset, no `done`; new start afterwards runs cleanly.
